// File: rtl/rns_pkg.sv
// Shared definitions for the sequential RNS ALU: opcodes, FSM states and
// constant helpers for modular inverses and coprimality checks.
package rns_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_CALC,
    ST_MRC1,
    ST_MRC2,
    ST_DONE
  } state_t;

  function automatic bit is_coprime(input int a, input int b);
    int x;
    int y;
    int tmp;
    x = a;
    y = b;
    while (y != 0) begin
      tmp = x % y;
      x   = y;
      y   = tmp;
    end
    return (x == 1);
  endfunction

  // Returns 0 when no inverse exists; the elaboration check rejects that case.
  function automatic int mod_inv(input int a, input int m);
    int r;
    r = 0;
    for (int x = m - 1; x >= 1; x--) begin
      if (((a % m) * x) % m == 1) r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/rns_mod_reduce.sv
// Combinational x mod MOD, evaluated in a width wide enough for both the
// input and the modulus so nothing is truncated before the reduction.
module rns_mod_reduce #(
  parameter int MOD   = 3,
  parameter int IN_W  = 4,
  parameter int OUT_W = $clog2(MOD)
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  localparam int MOD_W = $clog2(MOD + 1);
  localparam int CW0   = (IN_W > MOD_W) ? IN_W : MOD_W;
  localparam int CW    = (CW0 > OUT_W) ? CW0 : OUT_W;

  assign y = OUT_W'(CW'(x) % CW'(MOD));

endmodule

// File: rtl/rns_alu_seq.sv
// Sequential 3-channel RNS ALU: forward conversion, channel arithmetic and
// two-stage mixed-radix reverse conversion behind a valid/ready handshake.
module rns_alu_seq
  import rns_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int M1    = 3,
  parameter int M2    = 4,
  parameter int M3    = 5,
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  operand_a,
  input  logic [IN_W-1:0]  operand_b,
  input  logic [1:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             op_err
);

  localparam int M_MAX = (M1 > M2) ? ((M1 > M3) ? M1 : M3) : ((M2 > M3) ? M2 : M3);
  localparam int RES_W = (M_MAX > 2) ? $clog2(M_MAX) : 1;
  localparam int CW    = 2 * RES_W + 1;
  localparam int MW    = 2 * RES_W + 2;
  localparam int INV12 = mod_inv(M1, M2);
  localparam int INV13 = mod_inv(M1, M3);
  localparam int INV23 = mod_inv(M2, M3);

  if (M1 < 2 || M2 < 2 || M3 < 2 ||
      !is_coprime(M1, M2) || !is_coprime(M1, M3) || !is_coprime(M2, M3) ||
      (longint'(M1) * M2 * M3) > (longint'(1) << OUT_W)) begin : g_bad_params
    $error("rns_alu_seq: moduli must be >= 2, pairwise coprime and fit in OUT_W");
  end

  state_t state, state_next;

  logic [IN_W-1:0]             a_q, b_q;
  logic [1:0]                  op_q;
  logic [2:0][RES_W-1:0]       ra_q, rb_q, r_q;
  logic [2:0][RES_W-1:0]       fwd_a, fwd_b, calc_red;
  logic [2:0][CW-1:0]          calc_pre;
  logic                        err_q;
  logic [RES_W-1:0]            a1_q, a2_q, t_q;
  logic [RES_W-1:0]            a2_c, t_c, a3_c;
  logic [MW-1:0]               d2, d3, dt;
  logic [OUT_W-1:0]            res_c;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam int MI = (i == 0) ? M1 : ((i == 1) ? M2 : M3);

    rns_mod_reduce #(.MOD(MI), .IN_W(IN_W), .OUT_W(RES_W)) u_fwd_a (.x(a_q), .y(fwd_a[i]));
    rns_mod_reduce #(.MOD(MI), .IN_W(IN_W), .OUT_W(RES_W)) u_fwd_b (.x(b_q), .y(fwd_b[i]));

    // Sub adds MI first so the pre-reduction value can never go negative.
    assign calc_pre[i] = (op_q == OP_ADD) ? CW'(ra_q[i]) + CW'(rb_q[i]) :
                         (op_q == OP_SUB) ? CW'(ra_q[i]) + CW'(MI) - CW'(rb_q[i]) :
                                            CW'(ra_q[i]) * CW'(rb_q[i]);

    rns_mod_reduce #(.MOD(MI), .IN_W(CW), .OUT_W(RES_W)) u_calc (.x(calc_pre[i]), .y(calc_red[i]));
  end

  // Mixed-radix digits; earlier digits are reduced into the target modulus
  // before subtraction so unequal moduli are handled correctly.
  always_comb begin
    d2    = (MW'(r_q[1]) + MW'(M2) - (MW'(r_q[0]) % MW'(M2))) % MW'(M2);
    a2_c  = RES_W'((d2 * MW'(INV12)) % MW'(M2));
    d3    = (MW'(r_q[2]) + MW'(M3) - (MW'(r_q[0]) % MW'(M3))) % MW'(M3);
    t_c   = RES_W'((d3 * MW'(INV13)) % MW'(M3));
    dt    = (MW'(t_q) + MW'(M3) - (MW'(a2_q) % MW'(M3))) % MW'(M3);
    a3_c  = RES_W'((dt * MW'(INV23)) % MW'(M3));
    res_c = OUT_W'(a1_q) + OUT_W'(a2_q) * OUT_W'(M1) + OUT_W'(a3_c) * OUT_W'(M1 * M2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_FWD;
      end
      ST_FWD:  state_next = ST_CALC;
      ST_CALC: state_next = ST_MRC1;
      ST_MRC1: state_next = ST_MRC2;
      ST_MRC2: state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The result stays in its register after the hand-off until the next MRC2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      r_q       <= '0;
      err_q     <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      t_q       <= '0;
      result    <= '0;
      op_err    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q  <= operand_a;
            b_q  <= operand_b;
            op_q <= operation;
          end
        end
        ST_FWD: begin
          ra_q <= fwd_a;
          rb_q <= fwd_b;
        end
        ST_CALC: begin
          r_q   <= (op_q == OP_ILL) ? '0 : calc_red;
          err_q <= (op_q == OP_ILL);
        end
        ST_MRC1: begin
          a1_q <= r_q[0];
          a2_q <= a2_c;
          t_q  <= t_c;
        end
        ST_MRC2: begin
          result    <= res_c;
          op_err    <= err_q;
          out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_alu_seq.sv
// Randomised and directed checks of rns_alu_seq against an (A op B) mod 60
// reference model, including latency, backpressure and mid-operation reset.
module tb_rns_alu_seq;
  import rns_pkg::*;

  localparam int M_TOTAL = 3 * 4 * 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic [1:0] operation;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] result;
  logic       op_err;

  int tests_run    = 0;
  int tests_failed = 0;

  rns_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int ref_result(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % M_TOTAL;
      1:       return (((a - b) % M_TOTAL) + M_TOTAL) % M_TOTAL;
      2:       return (a * b) % M_TOTAL;
      default: return 0;
    endcase
  endfunction

  // Issues one transaction, checks the 4-cycle latency and the held result;
  // leaves the result un-accepted so callers can apply backpressure.
  task automatic applyStimulus(input int a, input int b, input int op);
    int    waited;
    string tag;
    tag    = $sformatf("a=%0d b=%0d op=%0d", a, b, op);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({"in_ready idle ", tag}, 32'(in_ready), 1);
    operand_a = 4'(a);
    operand_b = 4'(b);
    operation = 2'(op);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operand_a = 4'($urandom_range(0, 15));
    operand_b = 4'($urandom_range(0, 15));
    operation = 2'($urandom_range(0, 3));
    for (int n = 1; n < 4; n++) begin
      @(posedge clk); #1;
      checkOutput({"out_valid early ", tag}, 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    checkOutput({"out_valid k+4 ", tag}, 32'(out_valid), 1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({"result ", tag}, 32'(result), 32'(ref_result(a, b, op)));
    checkOutput({"op_err ", tag}, 32'(op_err), (op == 3) ? 1 : 0);
    checkOutput({"in_ready busy ", tag}, 32'(in_ready), 0);
  endtask

  task automatic acceptResult(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid drop", 32'(out_valid), 0);
    checkOutput("in_ready rise", 32'(in_ready), 1);
  endtask

  initial begin
    int a;
    int b;
    int op;
    int exp_res;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand_a = '0;
    operand_b = '0;
    operation = '0;
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 1);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset result", 32'(result), 0);
    checkOutput("reset op_err", 32'(op_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // out_ready with nothing pending must be harmless
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput("stray out_ready valid", 32'(out_valid), 0);
    checkOutput("stray out_ready in_ready", 32'(in_ready), 1);

    applyStimulus(9, 6, 0);  acceptResult(0);
    applyStimulus(6, 9, 1);  acceptResult(1);
    applyStimulus(9, 6, 1);  acceptResult(0);
    applyStimulus(15, 15, 2); acceptResult(2);
    applyStimulus(5, 5, 3);  acceptResult(0);
    applyStimulus(1, 2, 0);  acceptResult(0);

    // Backpressure: outputs frozen, new requests ignored
    applyStimulus(9, 6, 2);
    exp_res = ref_result(9, 6, 2);
    for (int n = 0; n < 10; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      operand_a = 4'($urandom_range(0, 15));
      operand_b = 4'($urandom_range(0, 15));
      operation = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      checkOutput("bp out_valid", 32'(out_valid), 1);
      checkOutput("bp result", 32'(result), 32'(exp_res));
      checkOutput("bp op_err", 32'(op_err), 0);
      checkOutput("bp in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    acceptResult(0);
    applyStimulus(7, 11, 0); acceptResult(0);

    // Reset while the transaction sits in CALC; op_err is still 1 from before
    applyStimulus(5, 5, 3);  acceptResult(0);
    operand_a = 4'd15;
    operand_b = 4'd15;
    operation = OP_MUL;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 0);
    checkOutput("midrst result", 32'(result), 0);
    checkOutput("midrst op_err", 32'(op_err), 0);
    checkOutput("midrst in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      checkOutput("post-reset no output", 32'(out_valid), 0);
    end

    // Exhaustive sweep with random consumer delay
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          applyStimulus(i, j, o);
          acceptResult($urandom_range(0, 2));
        end
      end
    end

    // Random transactions
    for (int n = 0; n < 150; n++) begin
      a  = $urandom_range(0, 15);
      b  = $urandom_range(0, 15);
      op = $urandom_range(0, 3);
      applyStimulus(a, b, op);
      acceptResult($urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
